// File: rtl/dwt_pkg.sv
`default_nettype none
// ============================================================================
// Module : dwt_pkg
// Shared constants and controller state encoding for the 5/3 lifting DWT.
// Rev    : 1.0  initial release
// ============================================================================
package dwt_pkg;

  localparam int DWT_SEG_LEN  = 16;
  localparam int DWT_SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    DRAIN = 3'd3
  } dwt_state_t;

endpackage
`default_nettype wire

// File: rtl/dwt_strobe_pipe.sv
`default_nettype none
// ============================================================================
// Module : dwt_strobe_pipe
// Two-stage strobe delay carrying {en, mirror, idx}; kill clears both stages.
// Rev    : 1.0  initial release
// ============================================================================
module dwt_strobe_pipe #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_kill,
  input  logic             i_en,
  input  logic             i_mirror,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_s1_en,
  output logic             o_s1_mirror,
  output logic             o_s2_en,
  output logic [IDX_W-1:0] o_s2_idx
);

  logic             r_s1_en;
  logic             r_s1_mirror;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s2_en;
  logic [IDX_W-1:0] r_s2_idx;

  // Qualifiers are zeroed when the strobe is idle so idle outputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_en     <= 1'b0;
      r_s1_mirror <= 1'b0;
      r_s1_idx    <= '0;
      r_s2_en     <= 1'b0;
      r_s2_idx    <= '0;
    end else if (i_kill) begin
      r_s1_en     <= 1'b0;
      r_s1_mirror <= 1'b0;
      r_s1_idx    <= '0;
      r_s2_en     <= 1'b0;
      r_s2_idx    <= '0;
    end else begin
      r_s1_en     <= i_en;
      r_s1_mirror <= i_en & i_mirror;
      r_s1_idx    <= i_en ? i_idx : '0;
      r_s2_en     <= r_s1_en;
      r_s2_idx    <= r_s1_idx;
    end
  end

  assign o_s1_en     = r_s1_en;
  assign o_s1_mirror = r_s1_mirror;
  assign o_s2_en     = r_s2_en;
  assign o_s2_idx    = r_s2_idx;

endmodule
`default_nettype wire

// File: rtl/dwt_lift_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dwt_lift_ctrl
// Segment sequencer for the streaming 5/3 lifting DWT: enables, mirrors, valids.
// Rev    : 1.0  initial release
// ============================================================================
module dwt_lift_ctrl
  import dwt_pkg::*;
#(
  parameter int SEG_LEN = DWT_SEG_LEN,
  parameter int CNT_W   = $clog2(SEG_LEN),
  parameter int IDX_W   = CNT_W - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             clr,
  output logic             shift_en,
  output logic             pred_en,
  output logic             pred_mirror,
  output logic             upd_en,
  output logic             upd_mirror,
  output logic             h_valid,
  output logic             l_valid,
  output logic [IDX_W-1:0] h_idx,
  output logic [IDX_W-1:0] l_idx,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(SEG_LEN - 1);

  dwt_state_t       r_state;
  dwt_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_k;
  logic [IDX_W-1:0] r_pred_idx;
  logic [IDX_W-1:0] w_pred_idx;
  logic             w_accept;
  logic             w_last;
  logic             w_pred_en;
  logic             w_pred_mirror;
  logic             w_busy;

  assign w_accept = in_valid & ~clr;
  assign shift_en = w_accept & ~reset;
  assign w_last   = (r_k == c_last);

  // Even k>=2 closes H[(k-2)/2]; the last odd sample closes H[SEG_LEN/2-1] by mirroring.
  assign w_pred_en     = w_accept & (w_last | (~r_k[0] & (r_k != '0)));
  assign w_pred_mirror = w_accept & w_last;
  assign w_pred_idx    = w_last ? r_k[CNT_W-1:1] : r_k[CNT_W-1:1] - IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
    end else if (clr) begin
      r_k <= '0;
    end else if (in_valid) begin
      r_k <= w_last ? '0 : r_k + CNT_W'(1);
    end
  end

  // Index of the H currently being predicted, feeding the update stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_idx <= '0;
    end else if (clr) begin
      r_pred_idx <= '0;
    end else begin
      r_pred_idx <= w_pred_en ? w_pred_idx : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_busy = pred_en | upd_en | h_valid | l_valid;

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else if (in_valid) begin
      if (w_last) begin
        w_state_nxt = DRAIN;
      end else if (r_k[0]) begin
        w_state_nxt = EVEN;
      end else begin
        w_state_nxt = ODD;
      end
    end else if (r_state == DRAIN && !w_busy) begin
      w_state_nxt = IDLE;
    end
  end

  assign state = r_state;

  dwt_strobe_pipe #(.IDX_W(IDX_W)) u_pipe_h (
    .clk         (clk),
    .rst         (reset),
    .i_kill      (clr),
    .i_en        (w_pred_en),
    .i_mirror    (w_pred_mirror),
    .i_idx       (w_pred_idx),
    .o_s1_en     (pred_en),
    .o_s1_mirror (pred_mirror),
    .o_s2_en     (h_valid),
    .o_s2_idx    (h_idx)
  );

  // Only L[0] lacks a left neighbour, so it reuses H[0].
  dwt_strobe_pipe #(.IDX_W(IDX_W)) u_pipe_l (
    .clk         (clk),
    .rst         (reset),
    .i_kill      (clr),
    .i_en        (pred_en),
    .i_mirror    (r_pred_idx == '0),
    .i_idx       (r_pred_idx),
    .o_s1_en     (upd_en),
    .o_s1_mirror (upd_mirror),
    .o_s2_en     (l_valid),
    .o_s2_idx    (l_idx)
  );

endmodule
`default_nettype wire

// File: tb/tb_dwt_lift_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dwt_lift_ctrl
// Directed self-checking bench for dwt_lift_ctrl with SEG_LEN=16.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dwt_lift_ctrl;
  import dwt_pkg::*;

  localparam int SEG_LEN = 16;
  localparam int IDX_W   = $clog2(SEG_LEN) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             clr;
  logic             shift_en;
  logic             pred_en;
  logic             pred_mirror;
  logic             upd_en;
  logic             upd_mirror;
  logic             h_valid;
  logic             l_valid;
  logic [IDX_W-1:0] h_idx;
  logic [IDX_W-1:0] l_idx;
  logic [2:0]       state;

  int vectors     = 0;
  int miscompares = 0;
  int hcnt;
  int lcnt;
  int ucnt;

  dwt_lift_ctrl #(.SEG_LEN(SEG_LEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .clr(clr),
    .shift_en(shift_en), .pred_en(pred_en), .pred_mirror(pred_mirror),
    .upd_en(upd_en), .upd_mirror(upd_mirror), .h_valid(h_valid),
    .l_valid(l_valid), .h_idx(h_idx), .l_idx(l_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // H index predicted in relative cycle r of a continuous stream of nseg segments, -1 if none.
  function automatic int pred_at(int r, int nseg);
    for (int s = 0; s < nseg; s++) begin
      int l;
      l = r - SEG_LEN * s;
      if (l >= 3 && l <= SEG_LEN - 1 && (l % 2) == 1) return (l - 3) / 2;
      if (l == SEG_LEN) return SEG_LEN / 2 - 1;
    end
    return -1;
  endfunction

  function automatic int exp_state(int r, int nseg);
    int last;
    last = SEG_LEN * nseg;
    if (r == 0) return int'(IDLE);
    if (r < last) begin
      if ((r % SEG_LEN) == 0) return int'(DRAIN);
      return ((r % 2) == 1) ? int'(ODD) : int'(EVEN);
    end
    if (r <= last + 3) return int'(DRAIN);
    return int'(IDLE);
  endfunction

  task automatic check_stream(input int r, input int nseg);
    int p0, p1, p2;
    p0 = pred_at(r, nseg);
    p1 = pred_at(r - 1, nseg);
    p2 = pred_at(r - 2, nseg);
    chk($sformatf("pred_en@%0d", r), pred_en, p0 >= 0);
    chk($sformatf("pred_mirror@%0d", r), pred_mirror, p0 == SEG_LEN / 2 - 1);
    chk($sformatf("upd_en@%0d", r), upd_en, p1 >= 0);
    chk($sformatf("upd_mirror@%0d", r), upd_mirror, p1 == 0);
    chk($sformatf("h_valid@%0d", r), h_valid, p1 >= 0);
    chk($sformatf("l_valid@%0d", r), l_valid, p2 >= 0);
    if (p1 >= 0) chk($sformatf("h_idx@%0d", r), h_idx, p1);
    if (p2 >= 0) chk($sformatf("l_idx@%0d", r), l_idx, p2);
    chk($sformatf("state@%0d", r), state, exp_state(r, nseg));
    if (h_valid) hcnt++;
    if (l_valid) lcnt++;
    if (upd_en)  ucnt++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".shift_en"}, shift_en, 0);
    chk({tag, ".pred_en"}, pred_en, 0);
    chk({tag, ".pred_mirror"}, pred_mirror, 0);
    chk({tag, ".upd_en"}, upd_en, 0);
    chk({tag, ".upd_mirror"}, upd_mirror, 0);
    chk({tag, ".h_valid"}, h_valid, 0);
    chk({tag, ".l_valid"}, l_valid, 0);
    chk({tag, ".h_idx"}, h_idx, 0);
    chk({tag, ".l_idx"}, l_idx, 0);
    chk({tag, ".state"}, state, int'(IDLE));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    hcnt = 0;
    lcnt = 0;
    ucnt = 0;
  endtask

  // Continuous stream of nseg segments, then idle until the controller settles.
  task automatic run_stream(input int nseg);
    for (int r = 0; r <= SEG_LEN * nseg + 5; r++) begin
      check_stream(r, nseg);
      in_valid = (r < SEG_LEN * nseg);
      #1;
      chk($sformatf("shift_en@%0d", r), shift_en, r < SEG_LEN * nseg);
      tick();
    end
    in_valid = 1'b0;
    chk("h_count", hcnt, (SEG_LEN / 2) * nseg);
    chk("l_count", lcnt, (SEG_LEN / 2) * nseg);
    chk("u_count", ucnt, (SEG_LEN / 2) * nseg);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;

    // Single segment, then drain back to IDLE.
    do_reset();
    run_stream(1);

    // Two back-to-back segments.
    do_reset();
    run_stream(2);

    // in_valid toggling: samples k=0..5 on even cycles only.
    do_reset();
    for (int r = 0; r <= 12; r++) begin
      chk($sformatf("tog.pred_en@%0d", r), pred_en, (r == 5) || (r == 9));
      chk($sformatf("tog.h_valid@%0d", r), h_valid, (r == 6) || (r == 10));
      if (r == 6)  chk("tog.h_idx@6", h_idx, 0);
      if (r == 10) chk("tog.h_idx@10", h_idx, 1);
      if (r == 2)  chk("tog.state@2", state, int'(ODD));
      if (r == 3)  chk("tog.state@3", state, int'(EVEN));
      in_valid = ((r % 2) == 0) && (r <= 10);
      tick();
    end
    in_valid = 1'b0;

    // clr while k=9 is presented with strobes in flight.
    do_reset();
    for (int r = 0; r <= 16; r++) begin
      if (r <= 9) check_stream(r, 1);
      else        check_stream(r - 10, 1);
      in_valid = 1'b1;
      clr      = (r == 9);
      #1;
      if (r == 9) chk("clr.shift_en", shift_en, 0);
      tick();
    end
    clr      = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset mid-segment, between clock edges.
    do_reset();
    in_valid = 1'b1;
    for (int r = 0; r <= 6; r++) tick();
    chk("arst.pred_before", pred_en, 1);
    #3;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_idle("arst");
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dwt_lift_ctrl.md
Name: dwt_lift_ctrl

Overview:
- Sequencing controller for the streaming 1-D 5/3 lifting DWT datapath in TOP. It sits between the 8-bit sample stream and the delay-line, predict and update registers.
- Counts samples within fixed-length segments and issues shift, predict and update enables.
- Drives the symmetric-extension mirror selects at segment edges.
- Flags which L_out/H_out cycles carry valid coefficients, so outputs no longer need boundary-don't-care handling.

Parameters:
- SEG_LEN, 16, samples per segment; even, >= 4.
- CNT_W, $clog2(SEG_LEN), width of the in-segment sample counter.
- IDX_W, CNT_W-1, width of the coefficient index outputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample is on in_data this cycle and is accepted at the clock edge.
- clr  in  1  synchronous segment restart; aborts the current segment.
- shift_en  out  1  advance the datapath delay line.
- pred_en  out  1  load the H (predict) register.
- pred_mirror  out  1  predict uses x[2n] in place of x[2n+2] (right edge).
- upd_en  out  1  load the L (update) register.
- upd_mirror  out  1  update uses H[n] in place of H[n-1] (left edge).
- h_valid  out  1  H_out holds a valid coefficient.
- l_valid  out  1  L_out holds a valid coefficient.
- h_idx  out  IDX_W  index n of the coefficient on H_out.
- l_idx  out  IDX_W  index n of the coefficient on L_out.
- state  out  3  controller state (debug, also drives TOP's state wire).

Behaviour:
- Reset (async, active-high): all outputs 0, counter k=0, state=IDLE. Outputs go low immediately on reset assertion, not at the next edge.
- shift_en = in_valid & ~clr (combinational). All other outputs are registered.
- Counter k (0..SEG_LEN-1):
  - Increments on each accepted sample.
  - Wraps to 0 after SEG_LEN-1.
  - Gaps in in_valid freeze k and all schedule generation; already-issued pipeline strobes still complete.
- Predict: sample k accepted in cycle c ->
  - k even and k >= 2: pred_en=1 in cycle c+1, pred_mirror=0, computes H[(k-2)/2].
  - k = SEG_LEN-1: pred_en=1 in cycle c+1, pred_mirror=1, computes H[SEG_LEN/2-1].
- Update: upd_en is pred_en delayed 1 cycle. upd_mirror=1 only for n=0 of each segment.
- Valid flags: h_valid is pred_en delayed 1 cycle; l_valid is upd_en delayed 1 cycle. h_idx and l_idx travel with their strobe.
- Per segment: exactly SEG_LEN/2 H and SEG_LEN/2 L strobes.
- States (3-bit encoding):
  - IDLE=0: after reset or clr.
  - EVEN=1: next sample has even k.
  - ODD=2: next sample has odd k.
  - DRAIN=3: segment done, strobes still in flight.
  - Transitions:
    - IDLE -> ODD on the first accept (k=0).
    - EVEN <-> ODD on each accept.
    - Accept of k=SEG_LEN-1 -> DRAIN.
    - DRAIN -> IDLE when the pipeline is empty and no new sample arrives.
    - DRAIN -> ODD if k=0 of the next segment arrives during DRAIN; back-to-back segments are legal.
- Overlap: the tail of segment s never collides with segment s+1. Its first predict is at least 3 cycles after its k=0.
- clr:
  - Forces k=0 and state=IDLE.
  - Kills pending pred/upd/valid strobes in the same cycle.
  - A sample presented with clr is discarded.
- clr with reset: reset dominates.
- Index widths: h_idx and l_idx wrap naturally at SEG_LEN/2. No saturation.

Decomposition:
- Package dwt_pkg holds:
  - state encoding localparams (IDLE, EVEN, ODD, DRAIN).
  - DWT_SEG_LEN default.
  - the 8-bit sample width constant shared with TOP.
- One sub-module: dwt_strobe_pipe. It is a 2-stage shift register carrying {en, mirror, idx} with a kill input. It is instantiated for pred->upd->l_valid and pred->h_valid.

Test Plan:
- Reset, then in_valid continuous from cycle 0 (SEG_LEN=16):
  - pred_en in cycles 3,5,...,15 and 16 (pred_mirror=1 only at 16).
  - upd_en 4..17, with upd_mirror at 4.
  - h_valid 4,6,...,16,17.
  - l_valid 5,...,18.
  - 8 of each strobe.
- Two back-to-back segments (32 samples):
  - second segment's pred_en at cycles 19..31 and 32.
  - no strobe lost or duplicated.
  - h_idx sequence 0..7,0..7.
- in_valid toggling 1,0,1,0: k advances only on high cycles; pred_en trails each even k>=2 by exactly 1 cycle.
- clr asserted at k=9 with strobes in flight:
  - all strobes drop next cycle, state=IDLE.
  - the next sample is k=0 and gets upd_mirror on its first update.
- Async reset mid-segment (k=6, between clock edges): every output reads 0 before the next clk edge.
- End-to-end with TOP using in_2.txt, checking H_out/L_out only when h_valid/l_valid: 0 mismatches against H_2.txt/L_2.txt.
